// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion streaming Nr+1 round keys over valid/ready.
// Optional round-key store with registered read port: define AES_KEY_SCHED_STORE_EN.
module aes_key_schedule #(
    parameter int unsigned NK       = 4,
    parameter int unsigned SBOX_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [NK*32-1:0] key,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [127:0]     rk,
    output logic [3:0]       rk_index,
    output logic             rk_last,
    output logic             done
`ifdef AES_KEY_SCHED_STORE_EN
    ,
    input  logic [3:0]       rd_idx,
    output logic [127:0]     rd_key
`endif
);
    localparam int unsigned NR    = NK + 6;
    localparam int unsigned TOTAL = 4 * (NR + 1);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_key_schedule: NK must be 4, 6 or 8");
    end
    if (SBOX_LAT > 2) begin : g_bad_lat
        $error("aes_key_schedule: SBOX_LAT must be 0..2");
    end

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int unsigned b = 0; b < 4; b++) r[8*b +: 8] = SBOX[w[8*b +: 8]];
        return r;
    endfunction

    typedef enum logic [2:0] {IDLE, LOAD, GEN, SUB, STALL} state_t;

    state_t      state, ret_state;
    logic [31:0] wbuf [NK];
    logic [31:0] asm_w [3];
    logic [1:0]  asm_cnt;
    logic [5:0]  i;
    logic [2:0]  imod;
    logic [7:0]  rcon;
    logic [1:0]  wcnt;
    logic [3:0]  key_cnt;
    logic [31:0] sub_q1, sub_q2;

    logic [31:0]  last_w, sub_in, sub_comb, sub_res, temp, new_word;
    logic [127:0] rk_next;
    logic         rot_needed, sub_needed, word_fire, out_free, asm_full, commit, rk_load, accept;

    always_comb begin
        last_w     = wbuf[NK-1];
        rot_needed = (imod == 3'd0);
        sub_needed = rot_needed || (NK == 8 && imod == 3'd4);
        sub_in     = rot_needed ? {last_w[23:0], last_w[31:24]} : last_w;
        sub_comb   = sub_word(sub_in);
        sub_res    = (SBOX_LAT == 0) ? sub_comb : (SBOX_LAT == 1) ? sub_q1 : sub_q2;
        if (!sub_needed)     temp = last_w;
        else if (rot_needed) temp = sub_res ^ {rcon, 24'h0};
        else                 temp = sub_res;
        // LOAD rotates the buffer so wbuf[0] walks through the key words in order
        new_word = (state == LOAD) ? wbuf[0] : (wbuf[0] ^ temp);
        case (state)
            LOAD:    word_fire = 1'b1;
            GEN:     word_fire = (i < 6'(TOTAL)) && (!sub_needed || SBOX_LAT == 0);
            SUB:     word_fire = (wcnt == 2'(SBOX_LAT));
            default: word_fire = 1'b0;
        endcase
        out_free = !rk_valid || rk_ready;
        asm_full = (asm_cnt == 2'd3);
        commit   = word_fire && (!asm_full || out_free);
        rk_load  = commit && asm_full;
        accept   = rk_valid && rk_ready;
        rk_next  = {asm_w[0], asm_w[1], asm_w[2], new_word};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ret_state <= IDLE;
            wbuf      <= '{default: '0};
            asm_w     <= '{default: '0};
            asm_cnt   <= '0;
            i         <= '0;
            imod      <= '0;
            rcon      <= 8'h01;
            wcnt      <= '0;
            key_cnt   <= '0;
            sub_q1    <= '0;
            sub_q2    <= '0;
            busy      <= 1'b0;
            rk_valid  <= 1'b0;
            rk        <= '0;
            rk_index  <= '0;
            rk_last   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done   <= 1'b0;
            sub_q1 <= sub_comb;
            sub_q2 <= sub_q1;

            if (accept && !rk_load) rk_valid <= 1'b0;
            if (rk_load) begin
                rk       <= rk_next;
                rk_valid <= 1'b1;
                rk_index <= key_cnt;
                rk_last  <= (key_cnt == 4'(NR));
                key_cnt  <= key_cnt + 4'd1;
            end

            if (commit) begin
                for (int unsigned k = 0; k < NK - 1; k++) wbuf[k] <= wbuf[k+1];
                wbuf[NK-1] <= new_word;
                if (asm_full) asm_cnt <= '0;
                else begin
                    asm_w[asm_cnt] <= new_word;
                    asm_cnt        <= asm_cnt + 2'd1;
                end
                i    <= i + 6'd1;
                imod <= (imod == 3'(NK-1)) ? 3'd0 : imod + 3'd1;
                if (state != LOAD && rot_needed)
                    rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end

            case (state)
                IDLE: if (start && !busy) begin
                    for (int unsigned k = 0; k < NK; k++) wbuf[k] <= key[(NK-1-k)*32 +: 32];
                    i       <= '0;
                    imod    <= '0;
                    rcon    <= 8'h01;
                    asm_cnt <= '0;
                    key_cnt <= '0;
                    busy    <= 1'b1;
                    state   <= LOAD;
                end
                LOAD: begin
                    if (commit && i == 6'(NK-1)) state <= GEN;
                    else if (word_fire && !commit) begin
                        ret_state <= LOAD;
                        state     <= STALL;
                    end
                end
                GEN: begin
                    if (i < 6'(TOTAL) && sub_needed && SBOX_LAT != 0) begin
                        wcnt  <= 2'd1;
                        state <= SUB;
                    end else if (word_fire && !commit) begin
                        ret_state <= GEN;
                        state     <= STALL;
                    end
                end
                SUB: begin
                    if (commit) state <= GEN;
                    else if (word_fire) begin
                        // S-box pipe keeps recomputing the same frozen input, so returning here is safe
                        ret_state <= SUB;
                        state     <= STALL;
                    end else wcnt <= wcnt + 2'd1;
                end
                STALL: if (out_free) state <= ret_state;
                default: state <= IDLE;
            endcase

            if (busy && accept && rk_last) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end

`ifdef AES_KEY_SCHED_STORE_EN
    logic [127:0] store_mem [15];

    always_ff @(posedge clk) begin
        if (rk_load) store_mem[key_cnt] <= rk_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_key <= '0;
        else          rd_key <= (rd_idx < 4'd15) ? store_mem[rd_idx] : '0;
    end
`endif
endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench: four key-schedule instances (NK=4 lat 1, NK=8, NK=4 lat 0, NK=4 lat 2)
// checked against FIPS-197 round keys.
module tb_aes_key_schedule;
    localparam int ND = 4;
    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] EXP128 [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        logic         last;
        bit           known;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n [ND];
    logic         start [ND];
    logic         rk_ready [ND];
    logic [255:0] key_in [ND];
    logic         busy [ND], rk_valid [ND], rk_last [ND], done [ND];
    logic [127:0] rk [ND];
    logic [3:0]   rk_idx [ND];
    logic [3:0]   rd_idx [ND];
    logic [127:0] rd_key [ND];

    exp_t         sbq [ND][$];
    int           n_tests = 0, n_fail = 0, cyc = 0;
    int           done_cnt [ND], done_cyc [ND];
    logic         hold_prev [ND];
    logic [127:0] rk_prev [ND];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_key_schedule #(.NK(4), .SBOX_LAT(1)) u_a (
        .clk(clk), .reset_n(rst_n[0]), .start(start[0]), .key(key_in[0][127:0]), .busy(busy[0]),
        .rk_valid(rk_valid[0]), .rk_ready(rk_ready[0]), .rk(rk[0]), .rk_index(rk_idx[0]),
        .rk_last(rk_last[0]), .done(done[0])
`ifdef AES_KEY_SCHED_STORE_EN
        , .rd_idx(rd_idx[0]), .rd_key(rd_key[0])
`endif
    );
    aes_key_schedule #(.NK(8), .SBOX_LAT(1)) u_b (
        .clk(clk), .reset_n(rst_n[1]), .start(start[1]), .key(key_in[1]), .busy(busy[1]),
        .rk_valid(rk_valid[1]), .rk_ready(rk_ready[1]), .rk(rk[1]), .rk_index(rk_idx[1]),
        .rk_last(rk_last[1]), .done(done[1])
`ifdef AES_KEY_SCHED_STORE_EN
        , .rd_idx(rd_idx[1]), .rd_key(rd_key[1])
`endif
    );
    aes_key_schedule #(.NK(4), .SBOX_LAT(0)) u_c (
        .clk(clk), .reset_n(rst_n[2]), .start(start[2]), .key(key_in[2][127:0]), .busy(busy[2]),
        .rk_valid(rk_valid[2]), .rk_ready(rk_ready[2]), .rk(rk[2]), .rk_index(rk_idx[2]),
        .rk_last(rk_last[2]), .done(done[2])
`ifdef AES_KEY_SCHED_STORE_EN
        , .rd_idx(rd_idx[2]), .rd_key(rd_key[2])
`endif
    );
    aes_key_schedule #(.NK(4), .SBOX_LAT(2)) u_d (
        .clk(clk), .reset_n(rst_n[3]), .start(start[3]), .key(key_in[3][127:0]), .busy(busy[3]),
        .rk_valid(rk_valid[3]), .rk_ready(rk_ready[3]), .rk(rk[3]), .rk_index(rk_idx[3]),
        .rk_last(rk_last[3]), .done(done[3])
`ifdef AES_KEY_SCHED_STORE_EN
        , .rd_idx(rd_idx[3]), .rd_key(rd_key[3])
`endif
    );

    task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < ND; d++) begin
            if (rst_n[d] === 1'b1) begin
                if (done[d] === 1'b1) begin
                    done_cnt[d]++;
                    done_cyc[d] = cyc;
                end
                if (rk_valid[d] === 1'b1 && rk_ready[d] === 1'b1) begin
                    if (sbq[d].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_rk dut%0d: got index %0d, expected no key", d, rk_idx[d]);
                    end else begin
                        e = sbq[d].pop_front();
                        chk("rk_index", d, 128'(rk_idx[d]), 128'(e.idx));
                        chk("rk_last", d, 128'(rk_last[d]), 128'(e.last));
                        if (e.known) chk("rk_value", d, rk[d], e.key);
                    end
                end
                if (hold_prev[d]) chk("rk_hold_stable", d, rk[d], rk_prev[d]);
                hold_prev[d] = rk_valid[d] && !rk_ready[d];
                rk_prev[d]   = rk[d];
            end else hold_prev[d] = 1'b0;
        end
    end

    task automatic push128(input int d);
        for (int r = 0; r < 11; r++) sbq[d].push_back('{EXP128[r], 4'(r), r == 10, 1'b1});
    endtask

    task automatic push256(input int d);
        logic [127:0] k;
        for (int r = 0; r < 15; r++) begin
            case (r)
                0:       k = K256[255:128];
                1:       k = K256[127:0];
                2:       k = 128'h9ba354118e6925afa51a8b5f2067fcde;
                14:      k = 128'hfe4890d1e6188d0b046df344706c631e;
                default: k = '0;
            endcase
            sbq[d].push_back('{k, 4'(r), r == 14, (r <= 2 || r == 14)});
        end
    endtask

    task automatic do_start(input int d);
        @(posedge clk); #1 start[d] = 1'b1;
        @(posedge clk); #1 start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int limit);
        int n;
        n = 0;
        while (done_cnt[d] == 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_cnt[d] == 0) $display("FAIL done_timeout dut%0d: got no done after %0d cycles, expected done", d, limit);
    endtask

    task automatic end_run(input int d);
        chk("done_pulses", d, 128'(done_cnt[d]), 128'd1);
        chk("queue_empty", d, 128'(sbq[d].size()), 128'd0);
        done_cnt[d] = 0;
    endtask

    initial begin
        int lat, n;
        for (int d = 0; d < ND; d++) begin
            rst_n[d] = 1'b0; start[d] = 1'b0; rk_ready[d] = 1'b0; key_in[d] = '0;
            rd_idx[d] = '0; done_cnt[d] = 0; done_cyc[d] = 0; hold_prev[d] = 1'b0;
        end
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", 0, 128'(busy[0]), '0);
        chk("rst_valid", 0, 128'(rk_valid[0]), '0);
        chk("rst_rk", 0, rk[0], '0);
        chk("rst_index", 0, 128'(rk_idx[0]), '0);
        chk("rst_last", 0, 128'(rk_last[0]), '0);
        chk("rst_done", 0, 128'(done[0]), '0);
        for (int d = 0; d < ND; d++) rst_n[d] = 1'b1;

        // SBOX_LAT 0 vs 2, started on the same edge with rk_ready held high
        key_in[2][127:0] = K128; key_in[3][127:0] = K128;
        push128(2); push128(3);
        rk_ready[2] = 1'b1; rk_ready[3] = 1'b1;
        @(posedge clk); #1 start[2] = 1'b1; start[3] = 1'b1;
        @(posedge clk); #1 start[2] = 1'b0; start[3] = 1'b0;
        lat = 1;
        while (rk_valid[2] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("start_to_valid_latency", 2, 128'(lat), 128'd5);
        wait_done(2, 400);
        wait_done(3, 400);
        chk("latency_build_delta", 3, 128'(done_cyc[3] - done_cyc[2]), 128'd20);
        end_run(2); end_run(3);

        // NK=4 with random backpressure, a forced 20-cycle hold and a start while busy
        key_in[0][127:0] = K128;
        push128(0);
        do_start(0);
        n = 0;
        while (done_cnt[0] == 0 && n < 2000) begin
            if (n >= 8 && n < 28) rk_ready[0] = 1'b0;
            else rk_ready[0] = ($urandom_range(0, 3) != 0);
            start[0] = (n == 30);
            key_in[0][127:0] = (n == 30) ? ~K128 : K128;
            @(posedge clk); #1;
            n++;
        end
        start[0] = 1'b0;
        key_in[0][127:0] = K128;
        if (done_cnt[0] == 0) $display("FAIL done_timeout dut0: got no done after %0d cycles, expected done", n);
        end_run(0);
`ifdef AES_KEY_SCHED_STORE_EN
        rd_idx[0] = 4'd10;
        @(posedge clk); #1;
        chk("store_rd_r10", 0, rd_key[0], EXP128[10]);
        rd_idx[0] = 4'd1;
        @(posedge clk); #1;
        chk("store_rd_r1", 0, rd_key[0], EXP128[1]);
`endif

        // reset after r3 is accepted, then a clean restart
        rk_ready[0] = 1'b1;
        push128(0);
        do_start(0);
        n = 0;
        while (sbq[0].size() > 7 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("keys_before_reset", 0, 128'(sbq[0].size()), 128'd7);
        rst_n[0] = 1'b0;
        #1;
        chk("abort_busy", 0, 128'(busy[0]), '0);
        chk("abort_valid", 0, 128'(rk_valid[0]), '0);
        chk("abort_rk", 0, rk[0], '0);
        chk("abort_index", 0, 128'(rk_idx[0]), '0);
        chk("abort_last", 0, 128'(rk_last[0]), '0);
        chk("abort_done", 0, 128'(done[0]), '0);
        sbq[0].delete();
        @(posedge clk); @(posedge clk); #1 rst_n[0] = 1'b1;
        repeat (3) @(posedge clk);
        chk("no_done_after_abort", 0, 128'(done_cnt[0]), '0);
        push128(0);
        do_start(0);
        wait_done(0, 400);
        end_run(0);

        // NK=8
        key_in[1] = K256;
        rk_ready[1] = 1'b1;
        push256(1);
        do_start(1);
        wait_done(1, 600);
        end_run(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
